// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared state encodings and requester side codes for the
//             instruction/data memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  // FSM state encoding (explicit 2-bit width)
  localparam int unsigned c_STATE_W = 2;
  localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
  localparam logic [c_STATE_W-1:0] c_ST_BUSY = 2'd1;
  localparam logic [c_STATE_W-1:0] c_ST_DONE = 2'd2;

  // Requester side codes; also used as bit indices into the request vector
  localparam logic c_SIDE_I = 1'b0;
  localparam logic c_SIDE_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Combinational two-way round-robin selector. A lone request wins
//             outright; on a tie the side that was not served last wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] reqs,   // bit c_SIDE_I = I request, bit c_SIDE_D = D request
  input  logic       last,   // side granted most recently
  output logic       valid,  // at least one request pending
  output logic       side    // selected side when valid
);

  // Pick the winner: tie alternates away from the last grant
  always_comb begin
    valid = |reqs;
    side  = c_SIDE_I;
    if (reqs[c_SIDE_I] && reqs[c_SIDE_D]) begin
      side = ~last;
    end else if (reqs[c_SIDE_D]) begin
      side = c_SIDE_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one main-memory port between the I-side and D-side cache
//             controllers. Round-robin on contention, one access in flight,
//             watchdog abort with ERR pulse if memory never answers.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IREQ,
  input  logic [AW-1:0] IADDR,
  output logic          IRDY,
  input  logic          DREQ,
  input  logic          DWE,
  input  logic [AW-1:0] DADDR,
  input  logic [DW-1:0] DDIN,
  output logic          DRDY,
  output logic [DW-1:0] RDATA,
  output logic          MREQ,
  output logic [AW-1:0] MADDR,
  output logic          MWE,
  output logic [DW-1:0] MWDATA,
  input  logic [DW-1:0] MRDATA,
  input  logic          MRDY,
  output logic          ERR
);

  // Abort fires at TIMEOUT-1, so the counter never needs to reach TIMEOUT
  localparam int unsigned      c_CW       = $clog2(TIMEOUT);
  localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(TIMEOUT - 1);

  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_next_state;
  logic [c_CW-1:0]      r_cnt;
  logic                 r_gnt;
  logic                 r_last;
  logic                 w_pick_valid;
  logic                 w_pick_side;
  logic                 w_grant;
  logic                 w_complete;
  logic                 w_abort;

  rr_pick2 u_pick (
    .reqs  ({DREQ, IREQ}),
    .last  (r_last),
    .valid (w_pick_valid),
    .side  (w_pick_side)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: if (w_grant) w_next_state = c_ST_BUSY;
      c_ST_BUSY: if (w_complete || w_abort) w_next_state = c_ST_DONE;
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  // FSM event decode: grant, memory completion, watchdog abort (MRDY wins)
  always_comb begin
    w_grant    = (r_state == c_ST_IDLE) && w_pick_valid;
    w_complete = (r_state == c_ST_BUSY) && MRDY;
    w_abort    = (r_state == c_ST_BUSY) && !MRDY && (r_cnt == c_CNT_LAST);
  end

  // Datapath, watchdog counter and completion pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MREQ   <= 1'b0;
      MWE    <= 1'b0;
      MADDR  <= '0;
      MWDATA <= '0;
      RDATA  <= '0;
      IRDY   <= 1'b0;
      DRDY   <= 1'b0;
      ERR    <= 1'b0;
      r_cnt  <= '0;
      r_gnt  <= c_SIDE_I;
      r_last <= c_SIDE_D;
    end else begin
      // Pulses last exactly one cycle (the DONE cycle)
      IRDY <= 1'b0;
      DRDY <= 1'b0;
      ERR  <= 1'b0;
      if (w_grant) begin
        MREQ   <= 1'b1;
        r_gnt  <= w_pick_side;
        r_last <= w_pick_side;
        r_cnt  <= '0;
        if (w_pick_side == c_SIDE_D) begin
          MADDR  <= DADDR;
          MWE    <= DWE;
          MWDATA <= DDIN;
        end else begin
          MADDR  <= IADDR;
          MWE    <= 1'b0;
        end
      end else if (w_complete || w_abort) begin
        MREQ <= 1'b0;
        MWE  <= 1'b0;
        if (w_abort) begin
          RDATA <= '0;
          ERR   <= 1'b1;
        end else if (!MWE) begin
          RDATA <= MRDATA;
        end
        if (r_gnt == c_SIDE_D) DRDY <= 1'b1;
        else                   IRDY <= 1'b1;
      end else if (r_state == c_ST_BUSY) begin
        r_cnt <= r_cnt + c_CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter (TIMEOUT = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IREQ = 1'b0;
  logic [AW-1:0] IADDR = '0;
  logic          IRDY;
  logic          DREQ = 1'b0;
  logic          DWE = 1'b0;
  logic [AW-1:0] DADDR = '0;
  logic [DW-1:0] DDIN = '0;
  logic          DRDY;
  logic [DW-1:0] RDATA;
  logic          MREQ;
  logic [AW-1:0] MADDR;
  logic          MWE;
  logic [DW-1:0] MWDATA;
  logic [DW-1:0] MRDATA = '0;
  logic          MRDY = 1'b0;
  logic          ERR;

  int n_vec = 0;
  int n_bad = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .IREQ(IREQ), .IADDR(IADDR), .IRDY(IRDY),
    .DREQ(DREQ), .DWE(DWE), .DADDR(DADDR), .DDIN(DDIN), .DRDY(DRDY),
    .RDATA(RDATA),
    .MREQ(MREQ), .MADDR(MADDR), .MWE(MWE), .MWDATA(MWDATA),
    .MRDATA(MRDATA), .MRDY(MRDY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    tick();
    n_vec++; if (MREQ !== 1'b0)   begin n_bad++; $display("FAIL rst_mreq got %b want 0", MREQ); end
    n_vec++; if (MWE !== 1'b0)    begin n_bad++; $display("FAIL rst_mwe got %b want 0", MWE); end
    n_vec++; if (MADDR !== '0)    begin n_bad++; $display("FAIL rst_maddr got %h want 0", MADDR); end
    n_vec++; if (MWDATA !== '0)   begin n_bad++; $display("FAIL rst_mwdata got %h want 0", MWDATA); end
    n_vec++; if (RDATA !== '0)    begin n_bad++; $display("FAIL rst_rdata got %h want 0", RDATA); end
    n_vec++; if ({IRDY, DRDY, ERR} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses got %b want 000", {IRDY, DRDY, ERR}); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_i_read();
    IREQ = 1'b1; IADDR = 32'h100;
    tick();
    n_vec++; if (MREQ !== 1'b1)      begin n_bad++; $display("FAIL ird_mreq got %b want 1", MREQ); end
    n_vec++; if (MADDR !== 32'h100)  begin n_bad++; $display("FAIL ird_maddr got %h want 100", MADDR); end
    n_vec++; if (MWE !== 1'b0)       begin n_bad++; $display("FAIL ird_mwe got %b want 0", MWE); end
    tick();
    n_vec++; if (IRDY !== 1'b0)      begin n_bad++; $display("FAIL ird_early got %b want 0", IRDY); end
    MRDY = 1'b1; MRDATA = 32'hDEADBEEF;
    tick();
    MRDY = 1'b0; MRDATA = '0;
    n_vec++; if (IRDY !== 1'b1)          begin n_bad++; $display("FAIL ird_irdy got %b want 1", IRDY); end
    n_vec++; if (DRDY !== 1'b0)          begin n_bad++; $display("FAIL ird_drdy got %b want 0", DRDY); end
    n_vec++; if (RDATA !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ird_rdata got %h want deadbeef", RDATA); end
    n_vec++; if (MREQ !== 1'b0)          begin n_bad++; $display("FAIL ird_mreq_drop got %b want 0", MREQ); end
    IREQ = 1'b0;
    tick();
    n_vec++; if ({IRDY, DRDY} !== 2'b00) begin n_bad++; $display("FAIL ird_pulse_len got %b want 00", {IRDY, DRDY}); end
  endtask

  task automatic test_d_write();
    DREQ = 1'b1; DWE = 1'b1; DADDR = 32'h200; DDIN = 32'h12345678;
    tick();
    n_vec++; if (MREQ !== 1'b1)           begin n_bad++; $display("FAIL dwr_mreq got %b want 1", MREQ); end
    n_vec++; if (MWE !== 1'b1)            begin n_bad++; $display("FAIL dwr_mwe got %b want 1", MWE); end
    n_vec++; if (MADDR !== 32'h200)       begin n_bad++; $display("FAIL dwr_maddr got %h want 200", MADDR); end
    n_vec++; if (MWDATA !== 32'h12345678) begin n_bad++; $display("FAIL dwr_mwdata got %h want 12345678", MWDATA); end
    DADDR = 32'h999; DDIN = 32'hFFFFFFFF;
    tick();
    n_vec++; if (MWDATA !== 32'h12345678) begin n_bad++; $display("FAIL dwr_frozen_wdata got %h want 12345678", MWDATA); end
    n_vec++; if (MADDR !== 32'h200)       begin n_bad++; $display("FAIL dwr_frozen_addr got %h want 200", MADDR); end
    MRDY = 1'b1; MRDATA = 32'h55555555;
    tick();
    MRDY = 1'b0; MRDATA = '0;
    n_vec++; if (DRDY !== 1'b1)           begin n_bad++; $display("FAIL dwr_drdy got %b want 1", DRDY); end
    n_vec++; if (IRDY !== 1'b0)           begin n_bad++; $display("FAIL dwr_irdy got %b want 0", IRDY); end
    n_vec++; if (RDATA !== 32'hDEADBEEF)  begin n_bad++; $display("FAIL dwr_rdata got %h want deadbeef", RDATA); end
    n_vec++; if ({MREQ, MWE} !== 2'b00)   begin n_bad++; $display("FAIL dwr_drop got %b want 00", {MREQ, MWE}); end
    DREQ = 1'b0; DWE = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    int hi;
    DREQ = 1'b1; DWE = 1'b0; DADDR = 32'h500;
    tick();
    hi = 0;
    while (MREQ === 1'b1 && hi < 30) begin
      hi++;
      tick();
    end
    n_vec++; if (hi != 8)                 begin n_bad++; $display("FAIL wd_busy_cycles got %0d want 8", hi); end
    n_vec++; if ({DRDY, ERR} !== 2'b11)   begin n_bad++; $display("FAIL wd_pulse got %b want 11", {DRDY, ERR}); end
    n_vec++; if (IRDY !== 1'b0)           begin n_bad++; $display("FAIL wd_irdy got %b want 0", IRDY); end
    n_vec++; if (RDATA !== '0)            begin n_bad++; $display("FAIL wd_rdata got %h want 0", RDATA); end
    DREQ = 1'b0;
    tick();
    n_vec++; if ({DRDY, ERR} !== 2'b00)   begin n_bad++; $display("FAIL wd_pulse_len got %b want 00", {DRDY, ERR}); end
    IREQ = 1'b1; IADDR = 32'h600;
    tick();
    n_vec++; if (MADDR !== 32'h600)       begin n_bad++; $display("FAIL wd_next_addr got %h want 600", MADDR); end
    MRDY = 1'b1; MRDATA = 32'h0BADF00D;
    tick();
    MRDY = 1'b0; MRDATA = '0;
    n_vec++; if ({IRDY, ERR} !== 2'b10)   begin n_bad++; $display("FAIL wd_next_done got %b want 10", {IRDY, ERR}); end
    n_vec++; if (RDATA !== 32'h0BADF00D)  begin n_bad++; $display("FAIL wd_next_rdata got %h want 0badf00d", RDATA); end
    IREQ = 1'b0;
    tick();
  endtask

  task automatic test_terminal_count();
    IREQ = 1'b1; IADDR = 32'h700;
    tick();
    for (int i = 0; i < 7; i++) tick();
    n_vec++; if (MREQ !== 1'b1)           begin n_bad++; $display("FAIL tc_mreq_held got %b want 1", MREQ); end
    MRDY = 1'b1; MRDATA = 32'hA5A5A5A5;
    tick();
    MRDY = 1'b0; MRDATA = '0;
    n_vec++; if ({IRDY, ERR} !== 2'b10)   begin n_bad++; $display("FAIL tc_done got %b want 10", {IRDY, ERR}); end
    n_vec++; if (RDATA !== 32'hA5A5A5A5)  begin n_bad++; $display("FAIL tc_rdata got %h want a5a5a5a5", RDATA); end
    IREQ = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int rdys;
    IREQ = 1'b1; IADDR = 32'h800;
    tick();
    n_vec++; if (MREQ !== 1'b1)           begin n_bad++; $display("FAIL ar_mreq_pre got %b want 1", MREQ); end
    #2 RST = 1'b1;
    #1;
    n_vec++; if (MREQ !== 1'b0)           begin n_bad++; $display("FAIL ar_mreq_async got %b want 0", MREQ); end
    IREQ = 1'b0;
    tick();
    RST = 1'b0;
    MRDY = 1'b1; MRDATA = 32'h77777777;
    rdys = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (IRDY === 1'b1 || DRDY === 1'b1 || MREQ === 1'b1) rdys++;
    end
    MRDY = 1'b0; MRDATA = '0;
    n_vec++; if (rdys != 0)               begin n_bad++; $display("FAIL ar_no_rdy got %0d want 0", rdys); end
    n_vec++; if (RDATA !== '0)            begin n_bad++; $display("FAIL ar_rdata got %h want 0", RDATA); end
  endtask

  task automatic test_contention();
    logic [AW-1:0] seen [4];
    logic [AW-1:0] want [4];
    int nacc, ni, nd, cyc;
    logic prev;
    want[0] = 32'h300; want[1] = 32'h400; want[2] = 32'h300; want[3] = 32'h400;
    IADDR = 32'h300; DADDR = 32'h400; DWE = 1'b0; MRDATA = 32'h11112222;
    IREQ = 1'b1; DREQ = 1'b1;
    nacc = 0; ni = 0; nd = 0; cyc = 0; prev = 1'b0;
    while ((ni + nd) < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (MREQ === 1'b1 && !prev && nacc < 4) begin
        seen[nacc] = MADDR;
        nacc++;
      end
      prev = MREQ;
      if (IRDY === 1'b1) ni++;
      if (DRDY === 1'b1) nd++;
      MRDY = MREQ;  // zero-wait memory
    end
    IREQ = 1'b0; DREQ = 1'b0; MRDY = 1'b0;
    n_vec++; if (nacc != 4) begin n_bad++; $display("FAIL rr_accesses got %0d want 4", nacc); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= nacc || seen[i] !== want[i]) begin
        n_bad++; $display("FAIL rr_addr%0d got %h want %h", i, (i < nacc) ? seen[i] : 32'hx, want[i]);
      end
    end
    n_vec++; if (ni != 2 || nd != 2) begin n_bad++; $display("FAIL rr_counts got i=%0d d=%0d want 2/2", ni, nd); end
    tick();
    tick();
    n_vec++; if (MREQ !== 1'b0) begin n_bad++; $display("FAIL rr_idle got %b want 0", MREQ); end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_watchdog();
    test_terminal_count();
    test_async_reset();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
